// File: rtl/cpu_bus_responder.sv
// CPU bus responder: zero-wait local RAM plus a stalled req/ack window to a slow
// peripheral port at 0xF000..0xFFFF, with timeout and a sticky bus error flag.
module cpu_bus_responder #(
  parameter int          RAM_AW   = 12,
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic [15:0] address,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q,
  output logic        stall,
  output logic        io_req,
  output logic        io_we,
  output logic [11:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [31:0] io_rdata,
  input  logic        io_ack,
  output logic        bus_err
);

  localparam int         RAM_DEPTH = 1 << RAM_AW;
  localparam logic [7:0] CNT_LAST  = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  cnt_r, cnt_s;
  logic [31:0] rdata_r, rdata_s;
  logic        io_req_s, io_we_s, bus_err_s;
  logic [11:0] io_addr_s;
  logic [31:0] io_wdata_s;
  logic        ram_sel_s, io_sel_s;
  logic [31:0] ram_r [0:RAM_DEPTH-1];

  assign ram_sel_s = (address >> RAM_AW) == 16'd0;
  assign io_sel_s  = address[15:12] == 4'hF;

  // Local RAM: write port only, contents survive reset
  always_ff @(posedge clk) begin
    if (wren && ram_sel_s) begin
      ram_r[address[RAM_AW-1:0]] <= data;
    end
  end

  // I/O handshake next-state and next register values
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    rdata_s    = rdata_r;
    io_req_s   = io_req;
    io_we_s    = io_we;
    io_addr_s  = io_addr;
    io_wdata_s = io_wdata;
    bus_err_s  = bus_err;
    case (state_r)
      IDLE: begin
        if (io_sel_s) begin
          io_addr_s  = address[11:0];
          io_we_s    = wren;
          io_wdata_s = data;
          io_req_s   = 1'b1;
          cnt_s      = 8'd0;
          state_s    = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        cnt_s = cnt_r + 8'd1;
        // ack has priority over a coincident timeout
        if (io_ack) begin
          if (!io_we) begin
            rdata_s = io_rdata;
          end else begin
            rdata_s = rdata_r;
          end
          io_req_s = 1'b0;
          state_s  = DONE;
        end else if (cnt_r == CNT_LAST) begin
          rdata_s   = ERR_WORD;
          bus_err_s = 1'b1;
          io_req_s  = 1'b0;
          state_s   = DONE;
        end else begin
          state_s = REQ;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        io_req_s = 1'b0;
        state_s  = IDLE;
      end
    endcase
  end

  // State and handshake registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_r  <= IDLE;
      cnt_r    <= 8'd0;
      rdata_r  <= 32'd0;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 12'd0;
      io_wdata <= 32'd0;
      bus_err  <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      rdata_r  <= rdata_s;
      io_req   <= io_req_s;
      io_we    <= io_we_s;
      io_addr  <= io_addr_s;
      io_wdata <= io_wdata_s;
      bus_err  <= bus_err_s;
    end
  end

  // Stall the CPU from the I/O decode cycle until the access leaves REQ
  always_comb begin
    stall = 1'b0;
    if (!nreset) begin
      stall = 1'b0;
    end else begin
      case (state_r)
        IDLE:    stall = io_sel_s;
        REQ:     stall = 1'b1;
        DONE:    stall = 1'b0;
        default: stall = 1'b0;
      endcase
    end
  end

  // Read data mux
  always_comb begin
    q = 32'd0;
    if (state_r == DONE) begin
      q = rdata_r;
    end else if (ram_sel_s) begin
      q = ram_r[address[RAM_AW-1:0]];
    end else begin
      q = 32'd0;
    end
  end

endmodule

// File: tb/tb_cpu_bus_responder.sv
// Directed bench for cpu_bus_responder: per-cycle vector table plus hand-built
// sequences for timeout, ack-on-timeout and reset during a pending access.
module tb_cpu_bus_responder;

  logic        clk;
  logic        nreset;
  logic [15:0] address;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q;
  logic        stall;
  logic        io_req;
  logic        io_we;
  logic [11:0] io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic        io_ack;
  logic        bus_err;

  int checks = 0;
  int errors = 0;

  cpu_bus_responder #(.RAM_AW(12), .TIMEOUT(16), .ERR_WORD(32'hDEADBEEF)) dut (
    .clk(clk), .nreset(nreset), .address(address), .data(data), .wren(wren),
    .q(q), .stall(stall), .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        nrst;
    logic [15:0] addr;
    logic [31:0] wdat;
    logic        we;
    logic        ack;
    logic [31:0] rdat;
    logic        exp_stall;
    logic        chk_q;
    logic [31:0] exp_q;
    logic        exp_req;
    logic        exp_err;
    logic        chk_io;
    logic        exp_we;
    logic [11:0] exp_addr;
    logic [31:0] exp_wdata;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkv(input logic [15:0] addr, input logic [31:0] wdat, input logic we,
                               input logic ack, input logic [31:0] rdat, input logic exp_stall,
                               input logic chk_q, input logic [31:0] exp_q, input logic exp_req,
                               input logic exp_err, input logic chk_io, input logic exp_we,
                               input logic [11:0] exp_addr, input logic [31:0] exp_wdata,
                               input string name);
    vec_t v;
    v.nrst = 1'b1; v.addr = addr; v.wdat = wdat; v.we = we; v.ack = ack; v.rdat = rdat;
    v.exp_stall = exp_stall; v.chk_q = chk_q; v.exp_q = exp_q; v.exp_req = exp_req;
    v.exp_err = exp_err; v.chk_io = chk_io; v.exp_we = exp_we; v.exp_addr = exp_addr;
    v.exp_wdata = exp_wdata; v.name = name;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive at negedge, compare just after, the posedge follows.
  task automatic cyc(input vec_t v);
    @(negedge clk);
    nreset = v.nrst; address = v.addr; data = v.wdat; wren = v.we;
    io_ack = v.ack; io_rdata = v.rdat;
    #1;
    chk({v.name, "/stall"}, {31'd0, stall}, {31'd0, v.exp_stall});
    chk({v.name, "/io_req"}, {31'd0, io_req}, {31'd0, v.exp_req});
    chk({v.name, "/bus_err"}, {31'd0, bus_err}, {31'd0, v.exp_err});
    if (v.chk_q) chk({v.name, "/q"}, q, v.exp_q);
    if (v.chk_io) begin
      chk({v.name, "/io_we"}, {31'd0, io_we}, {31'd0, v.exp_we});
      chk({v.name, "/io_addr"}, {20'd0, io_addr}, {20'd0, v.exp_addr});
      chk({v.name, "/io_wdata"}, io_wdata, v.exp_wdata);
    end
  endtask

  vec_t v;

  initial begin
    nreset = 1'b0; address = 16'h0000; data = 32'd0; wren = 1'b0;
    io_ack = 1'b0; io_rdata = 32'd0;
    #1;
    chk("reset/stall_low", {31'd0, stall}, 32'd0);
    @(negedge clk);
    address = 16'hF000;
    #1;
    chk("reset/stall_io_sel", {31'd0, stall}, 32'd0);
    chk("reset/io_req", {31'd0, io_req}, 32'd0);
    chk("reset/io_we", {31'd0, io_we}, 32'd0);
    chk("reset/io_addr", {20'd0, io_addr}, 32'd0);
    chk("reset/io_wdata", io_wdata, 32'd0);
    chk("reset/bus_err", {31'd0, bus_err}, 32'd0);
    @(negedge clk);

    // addr, wdata, we, ack, rdata, stall, chk_q, q, req, err, chk_io, we, io_addr, wdata, name
    vecs.push_back(mkv(16'h0010, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ram_wr10"));
    vecs.push_back(mkv(16'h0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ram_rd10"));
    vecs.push_back(mkv(16'h0000, 32'h0BADF00D, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ram_wr00"));
    vecs.push_back(mkv(16'hF004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iord_idle"));
    vecs.push_back(mkv(16'hF004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h004, 32'h0, "iord_req1"));
    vecs.push_back(mkv(16'hF004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iord_req2"));
    vecs.push_back(mkv(16'hF004, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iord_req3"));
    vecs.push_back(mkv(16'hF004, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iord_done"));
    vecs.push_back(mkv(16'h0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iord_after"));
    vecs.push_back(mkv(16'hF010, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iowr_idle"));
    vecs.push_back(mkv(16'hF010, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h99999999, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 12'h010, 32'hA5A5A5A5, "iowr_req1"));
    vecs.push_back(mkv(16'hF010, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "iowr_done"));
    vecs.push_back(mkv(16'h8000, 32'h11111111, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "unmap_wr"));
    vecs.push_back(mkv(16'h8000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "unmap_rd"));
    vecs.push_back(mkv(16'h0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0BADF00D, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ram_rd00"));
    vecs.push_back(mkv(16'hF020, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "b2b_a_idle"));
    vecs.push_back(mkv(16'hF020, 32'h0, 1'b0, 1'b1, 32'h11112222, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 32'h0, "b2b_a_req"));
    vecs.push_back(mkv(16'hF020, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h11112222, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "b2b_a_done"));
    vecs.push_back(mkv(16'hF030, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "b2b_b_idle"));
    vecs.push_back(mkv(16'hF030, 32'h0, 1'b0, 1'b1, 32'h33334444, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h030, 32'h0, "b2b_b_req"));
    vecs.push_back(mkv(16'hF030, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h33334444, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "b2b_b_done"));
    vecs.push_back(mkv(16'h0010, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "idle_ack"));
    vecs.push_back(mkv(16'h0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "idle_ack_after"));

    for (int i = 0; i < vecs.size(); i++) cyc(vecs[i]);

    // Ack arriving on the timeout cycle: data returned, no error
    cyc(mkv(16'hF040, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ackto_idle"));
    for (int k = 1; k <= 16; k++) begin
      cyc(mkv(16'hF040, 32'h0, 1'b0, (k == 16), 32'h55556666, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ackto_req"));
    end
    cyc(mkv(16'hF040, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h55556666, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "ackto_done"));

    // Timeout with no ack, then bus_err sticks across a good access
    cyc(mkv(16'hF050, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "to_idle"));
    for (int k = 1; k <= 16; k++) begin
      cyc(mkv(16'hF050, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "to_req"));
    end
    cyc(mkv(16'hF050, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, "to_done"));
    cyc(mkv(16'hF060, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, "post_to_idle"));
    cyc(mkv(16'hF060, 32'h0, 1'b0, 1'b1, 32'h77778888, 1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, "post_to_req"));
    cyc(mkv(16'hF060, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h77778888, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, "post_to_done"));

    // Reset while an access is pending, then a stale ack
    cyc(mkv(16'hF070, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h0, 32'h0, "rst_idle"));
    v = mkv(16'hF070, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 12'h070, 32'h0, "rst_mid_req");
    v.nrst = 1'b0;
    cyc(v);
    cyc(mkv(16'h0010, 32'h0, 1'b0, 1'b1, 32'hEEEEEEEE, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000, 32'h0, "rst_stale_ack"));
    cyc(mkv(16'h0010, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0, 32'h0, "rst_after"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_responder.md
Name: cpu_bus_responder

Overview:
- Memory-side responder for the CPU bus. Receives address/data/wren from the CPU and returns q and stall.
- Serves a zero-wait-state local RAM directly.
- Forwards the I/O window to a slow external peripheral port using a req/ack handshake. Holds the CPU with stall until the access completes or times out.
- Sits between the CPU core and its RAM/peripherals in the top level.

Parameters:
- RAM_AW, 12, local RAM address width (RAM occupies 0x0000..2^RAM_AW-1).
- TIMEOUT, 16, peripheral-cycle limit in REQ before an access is aborted; range 2..255.
- ERR_WORD, 32'hDEADBEEF, value returned on q for a timed-out I/O read.

Ports:
- clk  in  1  clock.
- nreset  in  1  reset, synchronous, active-low.
- address  in  16  CPU address bus.
- data  in  32  CPU write data.
- wren  in  1  CPU write enable.
- q  out  32  read data to CPU.
- stall  out  1  hold request to CPU (combinational).
- io_req  out  1  peripheral request (registered).
- io_we  out  1  peripheral write strobe, valid while io_req.
- io_addr  out  12  peripheral address, valid while io_req.
- io_wdata  out  32  peripheral write data, valid while io_req.
- io_rdata  in  32  peripheral read data, sampled with io_ack.
- io_ack  in  1  peripheral completion, one cycle or longer.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Clocking and reset: clk and nreset. nreset is synchronous and active-low.
- Decode:
  - ram_sel = address < 2^RAM_AW.
  - io_sel = address[15:12]==4'hF.
  - Everything else is unmapped.
- RAM region:
  - q = ram[address[RAM_AW-1:0]], asynchronous read, no stall.
  - Write on posedge when wren && ram_sel.
  - RAM contents are not reset.
- Unmapped region: q=0, writes dropped, stall=0.
- I/O FSM states: IDLE, REQ, DONE.
- IDLE:
  - stall = io_sel.
  - On the edge with io_sel: latch io_addr=address[11:0], io_we=wren, io_wdata=data; io_req<=1; clear cnt; go to REQ.
- REQ:
  - stall=1, cnt increments each cycle.
  - io_ack sampled high: rdata_q<=io_rdata (reads; writes leave rdata_q unchanged), io_req<=0, go to DONE.
  - Else if cnt==TIMEOUT-1: rdata_q<=ERR_WORD, bus_err<=1, io_req<=0, go to DONE.
  - ack and timeout in the same cycle: ack wins, bus_err not set.
- DONE:
  - stall=0, q=rdata_q for exactly one cycle.
  - Unconditionally go to IDLE.
  - A back-to-back I/O address in the next cycle starts a fresh access through IDLE.
- Minimum I/O latency is 2 stall cycles (ack in the first REQ cycle). Stall cycles = 1 + cycles spent in REQ.
- q mux: state DONE -> rdata_q; else ram_sel -> RAM; else 0. During IDLE/REQ with io_sel, q is don't-care (CPU is stalled).
- io_ack outside REQ is ignored.
- io_rdata is sampled only on the acking edge.
- Reset:
  - While nreset is low: stall=0.
  - Next edge: state=IDLE, io_req=0, io_we=0, io_addr=0, io_wdata=0, rdata_q=0, cnt=0, bus_err=0.
  - Reset mid-REQ drops io_req on that edge; any later io_ack is ignored.
- bus_err stays high until reset.

Test Plan:
- RAM write then read: wren=1, address=0x0010, data=0x12345678 for one edge; then address=0x0010, wren=0 -> q=0x12345678, stall=0 throughout.
- I/O read, ack after 3 REQ cycles with io_rdata=0xCAFEF00D at address 0xF004 -> io_addr=0x004, io_we=0, io_req high 3 cycles, stall high 4 cycles, then q=0xCAFEF00D with stall=0 for 1 cycle.
- I/O write: address=0xF010, wren=1, data=0xA5A5A5A5, ack on first REQ cycle -> io_we=1, io_wdata=0xA5A5A5A5, stall high exactly 2 cycles, bus_err=0.
- Timeout with TIMEOUT=16 and no ack -> io_req drops after 16 REQ cycles, q=0xDEADBEEF in DONE, bus_err=1 and stays 1 across later successful accesses.
- Ack on the timeout cycle -> read data returned, bus_err=0.
- Reset mid-REQ -> io_req=0 and stall=0 after the reset edge; stale ack afterwards causes no state change.
- Back-to-back I/O accesses -> each access gets its own handshake.
- Unmapped address 0x8000 read/write -> q=0, no stall, RAM unchanged.
